// File: rtl/axi_rd_arbiter_pkg.sv
// Shared types and AXI constants for the core read-port arbiter.
package axi_rd_arbiter_pkg;
   localparam int AXI_ADDR_W = 32;
   localparam int AXI_DATA_W = 32;
   localparam int AXI_ID_W   = 4;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] BURST_INCR  = 2'b01;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      RD   = 2'd2
   } state_e;
endpackage

// File: rtl/axi_rd_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first valid index after last_i, wrapping.
module rr_arbiter #(
   parameter int NREQ = 2,
   parameter int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic [NREQ-1:0] valid_i,
   input  logic [IDXW-1:0] last_i,
   output logic [NREQ-1:0] gnt_o,
   output logic [IDXW-1:0] idx_o,
   output logic            any_o
);
   int c;

   // Scan from last_i+1 around to last_i; the first hit wins.
   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      any_o = 1'b0;
      c     = 0;
      for (int k = 1; k <= NREQ; k++) begin
         c = (int'(last_i) + k) % NREQ;
         if (!any_o && valid_i[c]) begin
            any_o    = 1'b1;
            gnt_o[c] = 1'b1;
            idx_o    = IDXW'(c);
         end
      end
   end
endmodule

// File: rtl/axi_rd_arbiter.sv
// Shares the single AXI4 read port between NREQ requesters, one single-beat
// transaction outstanding at a time.
module axi_rd_arbiter
   import axi_rd_arbiter_pkg::*;
#(
   parameter int NREQ   = 2,
   parameter int ADDR_W = AXI_ADDR_W,
   parameter int DATA_W = AXI_DATA_W
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic [NREQ-1:0]          req_ar_valid_i,
   input  logic [NREQ*ADDR_W-1:0]   req_ar_addr_i,
   input  logic [NREQ*3-1:0]        req_ar_size_i,
   output logic [NREQ-1:0]          req_ar_ready_o,
   output logic [NREQ-1:0]          req_r_valid_o,
   output logic [DATA_W-1:0]        req_r_data_o,
   output logic [1:0]               req_r_resp_o,
   input  logic [NREQ-1:0]          req_r_ready_i,
   output logic                     io_master_arvalid,
   output logic [ADDR_W-1:0]        io_master_araddr,
   output logic [AXI_ID_W-1:0]      io_master_arid,
   output logic [7:0]               io_master_arlen,
   output logic [2:0]               io_master_arsize,
   output logic [1:0]               io_master_arburst,
   input  logic                     io_master_arready,
   input  logic                     io_master_rvalid,
   input  logic [DATA_W-1:0]        io_master_rdata,
   input  logic [1:0]               io_master_rresp,
   input  logic                     io_master_rlast,
   input  logic [AXI_ID_W-1:0]      io_master_rid,
   output logic                     io_master_rready
);
   localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

   state_e              state_q, state_d;
   logic [IDXW-1:0]     grant_q, grant_d;
   logic [IDXW-1:0]     last_q, last_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [2:0]          size_q, size_d;

   logic [NREQ-1:0]     pick_oh;
   logic [IDXW-1:0]     pick_idx;
   logic                pick_any;

   // Single beat only, so rlast carries no information.
   logic unused_rlast;
   assign unused_rlast = io_master_rlast;

   rr_arbiter #(.NREQ(NREQ), .IDXW(IDXW)) u_rr (
      .valid_i (req_ar_valid_i),
      .last_i  (last_q),
      .gnt_o   (pick_oh),
      .idx_o   (pick_idx),
      .any_o   (pick_any)
   );

   // AR payload always comes from the latched registers, so it holds under backpressure.
   assign io_master_araddr  = addr_q;
   assign io_master_arsize  = size_q;
   assign io_master_arid    = AXI_ID_W'(grant_q);
   assign io_master_arlen   = 8'd0;
   assign io_master_arburst = BURST_INCR;
   assign req_r_data_o      = io_master_rdata;

   // State register and latched transaction context.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state_q <= IDLE;
         grant_q <= '0;
         last_q  <= IDXW'(NREQ-1);
         addr_q  <= '0;
         size_q  <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         last_q  <= last_d;
         addr_q  <= addr_d;
         size_q  <= size_d;
      end
   end

   // Next state and handshake outputs; accept only in IDLE so arready never reaches ar_ready.
   always_comb begin
      state_d           = state_q;
      grant_d           = grant_q;
      last_d            = last_q;
      addr_d            = addr_q;
      size_d            = size_q;
      req_ar_ready_o    = '0;
      req_r_valid_o     = '0;
      req_r_resp_o      = io_master_rresp;
      io_master_arvalid = 1'b0;
      io_master_rready  = 1'b0;
      case (state_q)
         IDLE: begin
            // Gated by reset so a held valid is not acknowledged while in reset.
            if (pick_any && rst_i) begin
               req_ar_ready_o = pick_oh;
               grant_d        = pick_idx;
               addr_d         = req_ar_addr_i[int'(pick_idx)*ADDR_W +: ADDR_W];
               size_d         = req_ar_size_i[int'(pick_idx)*3 +: 3];
               state_d        = ADDR;
            end
         end
         ADDR: begin
            io_master_arvalid = 1'b1;
            if (io_master_arready) state_d = RD;
         end
         RD: begin
            req_r_valid_o[grant_q] = io_master_rvalid;
            io_master_rready       = req_r_ready_i[grant_q];
            // A response tagged for someone else is reported as a slave error.
            if (io_master_rid != AXI_ID_W'(grant_q)) req_r_resp_o = RESP_SLVERR;
            if (io_master_rvalid && req_r_ready_i[grant_q]) begin
               last_d  = grant_q;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end
endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed bench for axi_rd_arbiter: reset, contention, backpressure, error, mid-reset.
module tb_axi_rd_arbiter;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [1:0]  ar_valid = 2'b11;
   logic [31:0] a0 = 32'h8000_0000, a1 = 32'h3000_0100;
   logic [63:0] ar_addr;
   logic [5:0]  ar_size;
   logic [1:0]  ar_ready, r_valid, r_resp, r_ready = 2'b11;
   logic [31:0] r_data;
   logic        arvalid, arready = 1'b0, rvalid = 1'b0, rlast = 1'b1, rready;
   logic [31:0] araddr, rdata = '0;
   logic [3:0]  arid, rid = '0;
   logic [7:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst, rresp = 2'b00;

   int checks = 0;
   int errors = 0;

   assign ar_addr = {a1, a0};
   assign ar_size = {3'd3, 3'd2};

   always #5 clk = ~clk;

   axi_rd_arbiter dut (
      .clk_i(clk), .rst_i(rst),
      .req_ar_valid_i(ar_valid), .req_ar_addr_i(ar_addr), .req_ar_size_i(ar_size),
      .req_ar_ready_o(ar_ready), .req_r_valid_o(r_valid), .req_r_data_o(r_data),
      .req_r_resp_o(r_resp), .req_r_ready_i(r_ready),
      .io_master_arvalid(arvalid), .io_master_araddr(araddr), .io_master_arid(arid),
      .io_master_arlen(arlen), .io_master_arsize(arsize), .io_master_arburst(arburst),
      .io_master_arready(arready), .io_master_rvalid(rvalid), .io_master_rdata(rdata),
      .io_master_rresp(rresp), .io_master_rlast(rlast), .io_master_rid(rid),
      .io_master_rready(rready)
   );

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic idle_outs(input string tag);
      chk({tag, "_arvalid"}, 32'(arvalid), 32'd0);
      chk({tag, "_rvalid"},  32'(r_valid), 32'd0);
      chk({tag, "_rready"},  32'(rready),  32'd0);
   endtask

   // Full transaction with arready on the first ADDR cycle and rvalid on the first RD cycle.
   task automatic txn(input int g, input logic [31:0] a, input logic [2:0] sz,
                      input logic [31:0] d, input logic [3:0] id,
                      input logic [1:0] rsp, input logic [1:0] ersp);
      logic [1:0] oh;
      oh = 2'(1 << g);
      #1 chk("accept_ready", 32'(ar_ready), 32'(oh));
      tick(); #1;
      chk("addr_arvalid", 32'(arvalid), 32'd1);
      chk("addr_araddr",  araddr, a);
      chk("addr_arid",    32'(arid), 32'(g));
      chk("addr_arsize",  32'(arsize), 32'(sz));
      chk("addr_arready_hidden", 32'(ar_ready), 32'd0);
      arready = 1'b1;
      tick();
      arready = 1'b0;
      rvalid = 1'b1; rdata = d; rid = id; rresp = rsp;
      #1;
      chk("rd_arvalid", 32'(arvalid), 32'd0);
      chk("rd_rvalid",  32'(r_valid), 32'(oh));
      chk("rd_rdata",   r_data, d);
      chk("rd_resp",    32'(r_resp), 32'(ersp));
      chk("rd_rready",  32'(rready), 32'd1);
      tick();
      rvalid = 1'b0; rid = '0; rresp = 2'b00;
   endtask

   initial begin
      // Reset held with both requesters asserting valid.
      for (int i = 0; i < 3; i++) begin
         tick(); #1;
         idle_outs("reset");
         chk("reset_ar_ready", 32'(ar_ready), 32'd0);
      end
      rst = 1'b1;
      chk("const_arlen",   32'(arlen), 32'd0);
      chk("const_arburst", 32'(arburst), 32'd1);

      // Continuous contention: 0,1,0,1, first is the IFU fetch.
      txn(0, 32'h8000_0000, 3'd2, 32'h0010_0073, 4'd0, 2'b00, 2'b00);
      txn(1, 32'h3000_0100, 3'd3, 32'hCAFE_0001, 4'd1, 2'b00, 2'b00);
      a0 = 32'h8000_0004;
      txn(0, 32'h8000_0004, 3'd2, 32'h1234_5678, 4'd0, 2'b00, 2'b00);
      a1 = 32'h3000_0200;
      txn(1, 32'h3000_0200, 3'd3, 32'hA5A5_5A5A, 4'd1, 2'b00, 2'b00);

      // Mismatched rid on an IFU transaction: data passes, resp forced to SLVERR.
      ar_valid = 2'b01;
      txn(0, 32'h8000_0004, 3'd2, 32'h0BAD_F00D, 4'd1, 2'b00, 2'b10);

      // LSU read with AR and R backpressure; address input changes after accept.
      ar_valid = 2'b10;
      #1 chk("bp_accept", 32'(ar_ready), 32'd2);
      tick();
      ar_valid = 2'b00; a1 = 32'hDEAD_0000;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("bp_arvalid", 32'(arvalid), 32'd1);
         chk("bp_araddr",  araddr, 32'h3000_0200);
         tick();
      end
      arready = 1'b1;
      tick();
      arready = 1'b0;
      rvalid = 1'b1; rdata = 32'h7777_0000; rid = 4'd1; r_ready = 2'b01;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("bp_rready_low", 32'(rready), 32'd0);
         chk("bp_rvalid_held", 32'(r_valid), 32'd2);
         tick();
      end
      r_ready = 2'b11;
      #1 chk("bp_rready_high", 32'(rready), 32'd1);
      tick();
      rvalid = 1'b0;
      #1;
      idle_outs("bp_done");
      chk("bp_done_ready", 32'(ar_ready), 32'd0);

      // Reset while in RD: abandon and restart from reset grant pointer.
      ar_valid = 2'b10;
      tick();
      ar_valid = 2'b00;
      arready = 1'b1;
      tick();
      arready = 1'b0;
      #1 chk("mid_in_rd", 32'(r_valid), 32'd0);
      rst = 1'b0;
      tick();
      rst = 1'b1; rvalid = 1'b1; ar_valid = 2'b11;
      #1;
      idle_outs("mid_reset");
      chk("mid_reset_pick", 32'(ar_ready), 32'd1);
      tick();
      rvalid = 1'b0;
      #1;
      chk("mid_reset_arvalid", 32'(arvalid), 32'd1);
      chk("mid_reset_arid",    32'(arid), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
